tmds_decoder: RTL and testbench

// - Receive-side counterpart of the TMDS encoder: one instance per TMDS channel, after the 1:10 deserializer.
// - Aligns the 10-bit word boundary using control-token runs (bit slip).
// - Decodes each word to 8-bit pixel data, or to 2-bit control data plus DE.
// - Reports lock status. Three instances (with external HS/VS recovery) form a DVI receiver front end.

---
 rtl/tmds_decoder.sv | 229 ++++++++++++++++++++++
 tb/tb_tmds_decoder.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/tmds_decoder.sv
// tmds_decoder: receive path for one TMDS channel, placed after the 1:10
// deserializer. Finds the 10-bit word boundary from runs of control tokens,
// decodes data words to bytes and control tokens to {C1,C0}, and reports lock.
// Build option: define TMDS_BARREL_EN to align words internally with a barrel
// shifter instead of asking the deserializer for bit slips.
module tmds_decoder #(
  parameter int unsigned CTRL_RUN       = 8,
  parameter int unsigned SEARCH_TIMEOUT = 2048,
  parameter int unsigned LOSS_TIMEOUT   = 4096,
  parameter int unsigned SLIP_SETTLE    = 4
) (
  input  logic       I_pix_clk,
  input  logic       I_rst_n,
  input  logic [9:0] I_tmds,
  output logic [7:0] O_data,
  output logic [1:0] O_ctrl,
  output logic       O_de,
  output logic       O_locked,
  output logic       O_bitslip,
  output logic [3:0] O_slip_idx
);

  localparam int unsigned TMO_MAX = (SEARCH_TIMEOUT > SLIP_SETTLE) ? SEARCH_TIMEOUT : SLIP_SETTLE;
  localparam int unsigned RUN_W   = $clog2(CTRL_RUN + 1);
  localparam int unsigned TMO_W   = $clog2(TMO_MAX + 1);
  localparam int unsigned LOSS_W  = $clog2(LOSS_TIMEOUT + 1);

  localparam logic [RUN_W-1:0]  RUN_LOCK  = RUN_W'(CTRL_RUN);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(SEARCH_TIMEOUT - 1);
  localparam logic [TMO_W-1:0]  SETL_LAST = TMO_W'(SLIP_SETTLE - 1);
  localparam logic [LOSS_W-1:0] LOSS_MAX  = LOSS_W'(LOSS_TIMEOUT);

  localparam logic [9:0] TOK_00 = 10'b1101010100;
  localparam logic [9:0] TOK_01 = 10'b0010101011;
  localparam logic [9:0] TOK_10 = 10'b0101010100;
  localparam logic [9:0] TOK_11 = 10'b1010101011;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_SLIP   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_LOCKED = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [RUN_W-1:0]    run_q, run_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [LOSS_W-1:0]   loss_q, loss_d;
  logic [3:0]          idx_q, idx_d;

  logic [9:0]          w;
  logic [9:0]          w_q;
  logic                is_tok;
  logic [1:0]          tok_val;
  logic [7:0]          q;
  logic [7:0]          dec;

  logic [7:0]          data_q;
  logic [1:0]          ctrl_q;
  logic                de_q;

`ifdef TMDS_BARREL_EN
  logic [9:0]  in_q;
  logic [9:0]  prev_q;
  logic [19:0] cat;

  // Register the raw word and its predecessor so any 10-bit window can be cut.
  always_ff @(posedge I_pix_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      in_q   <= '0;
      prev_q <= '0;
    end else begin
      in_q   <= I_tmds;
      prev_q <= in_q;
    end
  end

  // Barrel select: the older word occupies the low bits, so idx counts
  // bits dropped from the front of the stream.
  always_comb begin
    cat = {in_q, prev_q};
    w   = cat[{1'b0, idx_q} +: 10];
  end
`else
  // External deserializer does the slipping; words arrive already aligned.
  always_comb begin
    w = I_tmds;
  end
`endif

  // Stage 1: aligned word register.
  always_ff @(posedge I_pix_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      w_q <= '0;
    end else begin
      w_q <= w;
    end
  end

  // Control token recognition on the stage-1 word.
  always_comb begin
    is_tok  = 1'b0;
    tok_val = '0;
    case (w_q)
      TOK_00: begin is_tok = 1'b1; tok_val = 2'b00; end
      TOK_01: begin is_tok = 1'b1; tok_val = 2'b01; end
      TOK_10: begin is_tok = 1'b1; tok_val = 2'b10; end
      TOK_11: begin is_tok = 1'b1; tok_val = 2'b11; end
      default: begin is_tok = 1'b0; tok_val = '0; end
    endcase
  end

  // Data decode: undo the optional inversion, then the XOR/XNOR chain.
  always_comb begin
    q      = w_q[9] ? ~w_q[7:0] : w_q[7:0];
    dec    = '0;
    dec[0] = q[0];
    for (int unsigned i = 1; i < 8; i++) begin
      dec[i] = w_q[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    end
  end

  // Alignment FSM state and counters.
  always_ff @(posedge I_pix_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q <= ST_SEARCH;
      run_q   <= '0;
      tmo_q   <= '0;
      loss_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      tmo_q   <= tmo_d;
      loss_q  <= loss_d;
      idx_q   <= idx_d;
    end
  end

  // Alignment FSM next state; tmo_cnt doubles as the settle counter.
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    tmo_d   = tmo_q;
    loss_d  = loss_q;
    idx_d   = idx_q;
    case (state_q)
      ST_SEARCH: begin
        run_d = is_tok ? run_q + 1'b1 : '0;
        if (run_d == RUN_LOCK) begin
          // Lock wins over a timeout landing on the same cycle.
          state_d = ST_LOCKED;
          run_d   = '0;
          tmo_d   = '0;
          loss_d  = '0;
        end else if (tmo_q == TMO_LAST) begin
          state_d = ST_SLIP;
          run_d   = '0;
          tmo_d   = '0;
          idx_d   = (idx_q == 4'd9) ? 4'd0 : idx_q + 4'd1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_SLIP: begin
        state_d = ST_SETTLE;
        tmo_d   = '0;
      end
      ST_SETTLE: begin
        if (tmo_q == SETL_LAST) begin
          state_d = ST_SEARCH;
          run_d   = '0;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_LOCKED: begin
        if (is_tok) begin
          loss_d = '0;
        end else if (loss_q != LOSS_MAX) begin
          loss_d = loss_q + 1'b1;
        end
        if (!is_tok && loss_d == LOSS_MAX) begin
          state_d = ST_SEARCH;
          run_d   = '0;
          tmo_d   = '0;
          loss_d  = '0;
        end
      end
      default: begin
        state_d = ST_SEARCH;
      end
    endcase
  end

  // Stage 2 outputs, gated by the lock decision taken on this same word so
  // O_locked and the decoded outputs change together.
  always_ff @(posedge I_pix_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      data_q <= '0;
      ctrl_q <= '0;
      de_q   <= 1'b0;
    end else if (state_d != ST_LOCKED) begin
      data_q <= '0;
      ctrl_q <= '0;
      de_q   <= 1'b0;
    end else if (is_tok) begin
      data_q <= '0;
      ctrl_q <= tok_val;
      de_q   <= 1'b0;
    end else begin
      data_q <= dec;
      de_q   <= 1'b1;
    end
  end

  assign O_data     = data_q;
  assign O_ctrl     = ctrl_q;
  assign O_de       = de_q;
  assign O_locked   = (state_q == ST_LOCKED);
  assign O_slip_idx = idx_q;
`ifdef TMDS_BARREL_EN
  assign O_bitslip  = 1'b0;
`else
  assign O_bitslip  = (state_q == ST_SLIP);
`endif

endmodule

// File: tb/tb_tmds_decoder.sv
// Directed bench for tmds_decoder: lock, data/control decode, loss of lock,
// bit-slip search against a modelled deserializer, reset during a slip.
// Define TMDS_BARREL_EN for both files to exercise the internal aligner.
module tb_tmds_decoder;

  localparam logic [9:0] TOK00 = 10'b1101010100;
  localparam logic [9:0] TOK11 = 10'b1010101011;
  localparam int         SLIP_PERIOD = 2048 + 1 + 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [9:0] tmds = '0;
  logic [7:0] data;
  logic [1:0] ctrl;
  logic       de;
  logic       locked;
  logic       bitslip;
  logic [3:0] slip_idx;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Deserializer model state: previous stream word and current bit offset.
  logic [9:0] prev_s = '0;
  int         off    = 0;

  logic [7:0] bytes_v [4] = '{8'h00, 8'hFF, 8'h55, 8'hA3};
  bit         inv_v   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

  tmds_decoder #(
    .CTRL_RUN       (8),
    .SEARCH_TIMEOUT (2048),
    .LOSS_TIMEOUT   (4096),
    .SLIP_SETTLE    (4)
  ) dut (
    .I_pix_clk  (clk),
    .I_rst_n    (rst_n),
    .I_tmds     (tmds),
    .O_data     (data),
    .O_ctrl     (ctrl),
    .O_de       (de),
    .O_locked   (locked),
    .O_bitslip  (bitslip),
    .O_slip_idx (slip_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Transmit-side TMDS encoding (transition minimisation, optional inversion).
  function automatic logic [9:0] tmds_enc(input logic [7:0] b, input bit inv);
    logic [8:0] qm;
    bit         use_xnor;
    int         n1;
    n1       = $countones(b);
    use_xnor = (n1 > 4) || (n1 == 4 && b[0] == 1'b0);
    qm       = '0;
    qm[0]    = b[0];
    for (int i = 1; i < 8; i++) qm[i] = use_xnor ? ~(qm[i-1] ^ b[i]) : (qm[i-1] ^ b[i]);
    qm[8] = ~use_xnor;
    return {inv, qm[8], inv ? ~qm[7:0] : qm[7:0]};
  endfunction

  task automatic tick(input logic [9:0] word);
    tmds = word;
    @(posedge clk);
    #1;
  endtask

  // Present stream word s shifted by 'off' bits (off=10 means aligned).
  task automatic feed_rot(input logic [9:0] s);
    logic [19:0] cat;
    cat    = {s, prev_s};
    tmds   = cat[off +: 10];
    prev_s = s;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tmds  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {15'b0, data, ctrl, de, locked, bitslip, slip_idx}, 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [9:0] fill;
    logic [9:0] wv;
    int         lock_tick;
    int         n_pulse;
    int         last_t;
    bit         seen;

    fill = tmds_enc(8'h00, 1'b0);
    do_reset();

`ifdef TMDS_BARREL_EN
    // Stream delayed by 6 bits: aligned when the window starts 6 bits in.
    off    = 4;
    prev_s = TOK00;
    seen   = 1'b0;
    for (int t = 0; t < 16000; t++) begin
      feed_rot(TOK00);
      if (bitslip) seen = 1'b1;
      if (locked) break;
    end
    check("brl_locked", {31'b0, locked}, 32'd1);
    check("brl_slip_idx", {28'b0, slip_idx}, 32'd6);
    for (int j = 0; j < 7; j++) begin
      if (j < 4) wv = tmds_enc(bytes_v[j], inv_v[j]);
      else       wv = fill;
      feed_rot(wv);
      if (bitslip) seen = 1'b1;
      if (j == 2) check("brl_latency_not_2", {31'b0, de}, 32'd0);
      if (j >= 3) begin
        check("brl_data", {24'b0, data}, {24'b0, bytes_v[j-3]});
        check("brl_de", {31'b0, de}, 32'd1);
      end
    end
    check("brl_no_pin_slip", {31'b0, seen}, 32'd0);
`else
    // Lock from a clean run of 00 tokens.
    lock_tick = 0;
    for (int t = 1; t <= 10; t++) begin
      tick(TOK00);
      if (locked && lock_tick == 0) lock_tick = t;
    end
    check("lock_tick", lock_tick, 32'd9);
    check("lock_ctrl", {30'b0, ctrl}, 32'd0);
    check("lock_de", {31'b0, de}, 32'd0);

    // Data bytes round-trip, two cycles from input to output.
    for (int j = 0; j < 5; j++) begin
      if (j < 4) wv = tmds_enc(bytes_v[j], inv_v[j]);
      else       wv = fill;
      tick(wv);
      if (j >= 1) begin
        check("data_byte", {24'b0, data}, {24'b0, bytes_v[j-1]});
        check("data_de", {31'b0, de}, 32'd1);
      end
    end

    // Control token 11, then data: O_ctrl holds across the data word.
    tick(TOK11);
    tick(fill);
    check("ctrl11_val", {22'b0, ctrl, de, data}, {22'b0, 2'b11, 1'b0, 8'h00});
    tick(fill);
    check("ctrl11_hold", {22'b0, ctrl, de, data}, {22'b0, 2'b11, 1'b1, 8'h00});

    // Token arriving as the 4096th word keeps lock.
    tick(TOK00);
    repeat (4095) tick(fill);
    tick(TOK00);
    tick(fill);
    check("keep_on_timeout", {31'b0, locked}, 32'd1);
    repeat (3) tick(fill);
    check("keep_after", {31'b0, locked}, 32'd1);

    // 4096 data words with no token drop lock.
    tick(TOK11);
    for (int n = 1; n <= 4096; n++) tick(fill);
    check("loss_still_locked", {31'b0, locked}, 32'd1);
    tick(fill);
    check("loss_drop", {20'b0, locked, de, ctrl, data}, 32'd0);
    repeat (3) tick(TOK11);
    check("unlocked_gated", {20'b0, locked, de, ctrl, data}, 32'd0);

    // A data word inside the run restarts the count.
    do_reset();
    repeat (7) tick(TOK00);
    tick(fill);
    repeat (7) tick(TOK00);
    tick(fill);
    tick(fill);
    check("run_cleared", {31'b0, locked}, 32'd0);

    // Stream ahead by 3 bits: seven slips to realign.
    do_reset();
    off     = 3;
    prev_s  = TOK00;
    n_pulse = 0;
    last_t  = 0;
    for (int t = 0; t < 16000; t++) begin
      feed_rot(TOK00);
      if (bitslip) begin
        if (n_pulse > 0) check("slip_gap", t - last_t, SLIP_PERIOD);
        last_t = t;
        n_pulse++;
        if (off < 10) off++;
      end
      if (locked) break;
    end
    check("slip_count", n_pulse, 32'd7);
    check("slip_locked", {31'b0, locked}, 32'd1);
    check("slip_idx_final", {28'b0, slip_idx}, 32'd7);

    // Reset asserted during the SLIP cycle.
    do_reset();
    seen = 1'b0;
    for (int t = 0; t < 2200; t++) begin
      tick(fill);
      if (bitslip) begin
        seen = 1'b1;
        break;
      end
    end
    check("slip_seen", {31'b0, seen}, 32'd1);
    check("slip_idx_one", {28'b0, slip_idx}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_in_slip", {26'b0, locked, bitslip, slip_idx}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (9) tick(TOK00);
    check("relock_after_rst", {27'b0, locked, slip_idx}, 32'h10);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
